// File: rtl/lsu_wb_pkg.sv
// Shared encodings for the LSU Wishbone master: RISC-V access sizes and FSM states.
package lsu_wb_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_wb_master_if.sv
// Wishbone pipelined bus between the LSU master and a single slave.
interface lsu_wb_master_if;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables/replication, misalignment detect, load extraction.
module lsu_lane_align
  import lsu_wb_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_offs,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_sel,
  output logic [31:0] st_dat,
  output logic        st_misalign,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_offs,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_sel      = 4'b0000;
    st_dat      = 32'h0;
    st_misalign = 1'b0;
    case (st_size)
      SZ_B, SZ_BU: begin
        st_sel = 4'b0001 << st_offs;
        st_dat = {4{st_wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        st_sel      = 4'b0011 << st_offs;
        st_dat      = {2{st_wdata[15:0]}};
        st_misalign = st_offs[0];
      end
      SZ_W: begin
        st_sel      = 4'b1111;
        st_dat      = st_wdata;
        st_misalign = |st_offs;
      end
      // Encodings 011 and 11x are not legal load/store widths.
      default: st_misalign = 1'b1;
    endcase
  end

  always_comb begin
    ld_shifted = ld_raw >> {ld_offs, 3'b000};
    ld_data    = 32'h0;
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_W:    ld_data = ld_shifted;
      SZ_BU:   ld_data = {24'h0, ld_shifted[7:0]};
      SZ_HU:   ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// Single-outstanding LSU to Wishbone pipelined master with misalign trap and ack timeout.
//   state    | meaning
//   IDLE     | ready for a CPU request
//   REQ      | cyc+stb asserted, waiting for the slave to take it (stall low)
//   WAIT_ACK | cyc only, waiting for ack/err or timeout
//   RESP     | one-cycle response pulse to the CPU
module lsu_wb_master
  import lsu_wb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  lsu_wb_master_if.master wb
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  lsu_state_e       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [3:0]  st_sel;
  logic [31:0] st_dat;
  logic        st_misalign;
  logic [31:0] ld_data;
  logic        timed_out;
  logic        bus_live;
  logic        bus_done;

  lsu_lane_align u_align (
    .st_size     (req_size),
    .st_offs     (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .st_sel      (st_sel),
    .st_dat      (st_dat),
    .st_misalign (st_misalign),
    .ld_size     (size_q),
    .ld_offs     (addr_q[1:0]),
    .ld_raw      (wb.wb_dat_i),
    .ld_data     (ld_data)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= 32'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'b0000;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Once the count hits TIMEOUT the cycle is already abandoned, so a late ack is ignored.
  assign timed_out = (state_q == ST_WAIT_ACK) && (cnt_q == CNT_MAX);
  assign bus_live  = ((state_q == ST_REQ) && !wb.wb_stall_i) ||
                     ((state_q == ST_WAIT_ACK) && !timed_out);
  assign bus_done  = bus_live && (wb.wb_ack_i || wb.wb_err_i);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          addr_d = req_addr;
          dat_d  = st_dat;
          sel_d  = st_sel;
          if (st_misalign) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus_done) begin
          state_d = ST_RESP;
          err_d   = !wb.wb_ack_i;
          rdata_d = (wb.wb_ack_i && !we_q) ? ld_data : 32'h0;
        end else if (!wb.wb_stall_i) begin
          state_d = ST_WAIT_ACK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (timed_out) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (bus_done) begin
          state_d = ST_RESP;
          err_d   = !wb.wb_ack_i;
          rdata_d = (wb.wb_ack_i && !we_q) ? ld_data : 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

  assign wb.wb_cyc_o = (state_q == ST_REQ) || ((state_q == ST_WAIT_ACK) && !timed_out);
  assign wb.wb_stb_o = (state_q == ST_REQ);
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = {addr_q[31:2], 2'b00};
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Scoreboard bench for lsu_wb_master against a registered-ack Wishbone slave model.
module tb_lsu_wb_master;
  import lsu_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = SZ_W;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  lsu_wb_master_if wb_bus ();

  lsu_wb_master #(.TIMEOUT(15)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .wb         (wb_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Slave model knobs, written only by the stimulus process.
  int   stall_cfg  = 0;
  logic no_ack     = 1'b0;
  logic give_err   = 1'b0;
  logic inject_ack = 1'b0;

  logic [31:0] mem [64];
  int          stall_seen = 0;
  logic        ack_q = 1'b0;
  logic        err_q = 1'b0;
  logic [31:0] rd_q  = 32'h0;
  logic        stall_now;

  assign stall_now         = wb_bus.wb_cyc_o && wb_bus.wb_stb_o && (stall_seen < stall_cfg);
  assign wb_bus.wb_stall_i = stall_now;
  assign wb_bus.wb_ack_i   = ack_q | inject_ack;
  assign wb_bus.wb_err_i   = err_q;
  assign wb_bus.wb_dat_i   = rd_q;

  always @(posedge clk) begin
    ack_q <= 1'b0;
    err_q <= 1'b0;
    if (!wb_bus.wb_cyc_o) begin
      stall_seen <= 0;
    end else if (stall_now) begin
      stall_seen <= stall_seen + 1;
    end else if (wb_bus.wb_stb_o) begin
      if (give_err) begin
        err_q <= 1'b1;
      end else if (!no_ack) begin
        ack_q <= 1'b1;
        if (wb_bus.wb_we_o) begin
          for (int i = 0; i < 4; i++)
            if (wb_bus.wb_sel_o[i]) mem[wb_bus.wb_adr_o[7:2]][8*i +: 8] <= wb_bus.wb_dat_o[8*i +: 8];
        end else begin
          rd_q <= mem[wb_bus.wb_adr_o[7:2]];
        end
      end
    end
  end

  // Drives one request, pushes its expected response, then watches the bus until resp_valid.
  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                         output int lat, output int stb_n, output int wait_n, output int cyc_n,
                         output logic [3:0] sel_s, output logic [31:0] dat_s,
                         output logic [31:0] adr_s, output logic we_s);
    exp_t e;
    exp_t got;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_before_req: ready=%b resp_valid=%b, want ready=1 resp_valid=0", req_ready, resp_valid);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; stb_n = 0; wait_n = 0; cyc_n = 0;
    sel_s = 4'h0; dat_s = 32'h0; adr_s = 32'h0; we_s = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (wb_bus.wb_cyc_o) cyc_n++;
      if (wb_bus.wb_stb_o) begin
        stb_n++;
        sel_s = wb_bus.wb_sel_o;
        dat_s = wb_bus.wb_dat_o;
        adr_s = wb_bus.wb_adr_o;
        we_s  = wb_bus.wb_we_o;
      end
      if (wb_bus.wb_cyc_o && !wb_bus.wb_stb_o) wait_n++;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    n_tests++;
    got = sb_q.pop_front();
    if (lat == 0) begin
      n_fail++;
      $display("FAIL resp_wait: no resp_valid within 40 cycles for addr %h", addr);
    end else if (resp_rdata !== got.rdata || resp_err !== got.err) begin
      n_fail++;
      $display("FAIL sb_resp addr=%h: got rdata=%h err=%b, want rdata=%h err=%b",
               addr, resp_rdata, resp_err, got.rdata, got.err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_we_o, wb_bus.wb_sel_o} !== 7'b0 ||
        wb_bus.wb_adr_o !== 32'h0 || wb_bus.wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, want all zero",
               wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_we_o, wb_bus.wb_sel_o, wb_bus.wb_adr_o, wb_bus.wb_dat_o);
    end
    n_tests++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_resp: valid=%b err=%b rdata=%h, want 0/0/0", resp_valid, resp_err, resp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word;
    int lat, stb_n, wait_n, cyc_n; logic [3:0] sel_s; logic [31:0] dat_s, adr_s; logic we_s;
    run_txn(1'b1, SZ_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    n_tests++;
    if (sel_s !== 4'hF || dat_s !== 32'hDEADBEEF || adr_s !== 32'h100 || we_s !== 1'b1) begin
      n_fail++;
      $display("FAIL store_w_bus: sel=%h dat=%h adr=%h we=%b, want F DEADBEEF 00000100 1", sel_s, dat_s, adr_s, we_s);
    end
    n_tests++;
    if (lat != 3 || stb_n != 1) begin
      n_fail++;
      $display("FAIL store_w_timing: resp at %0d stb %0d cycles, want 3 and 1", lat, stb_n);
    end
    run_txn(1'b0, SZ_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    n_tests++;
    if (lat != 3 || sel_s !== 4'hF || we_s !== 1'b0) begin
      n_fail++;
      $display("FAIL load_w: resp at %0d sel=%h we=%b, want 3 F 0", lat, sel_s, we_s);
    end
  endtask

  task automatic test_byte;
    int lat, stb_n, wait_n, cyc_n; logic [3:0] sel_s; logic [31:0] dat_s, adr_s; logic we_s;
    run_txn(1'b1, SZ_W, 32'h100, 32'h0000_8000, 32'h0, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    run_txn(1'b0, SZ_B, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    n_tests++;
    if (sel_s !== 4'b0010 || adr_s !== 32'h100) begin
      n_fail++;
      $display("FAIL load_b_bus: sel=%b adr=%h, want 0010 00000100", sel_s, adr_s);
    end
    run_txn(1'b0, SZ_BU, 32'h101, 32'h0, 32'h00000080, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
  endtask

  task automatic test_half;
    int lat, stb_n, wait_n, cyc_n; logic [3:0] sel_s; logic [31:0] dat_s, adr_s; logic we_s;
    run_txn(1'b1, SZ_H, 32'h102, 32'hABCD1234, 32'h0, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    n_tests++;
    if (sel_s !== 4'b1100 || dat_s !== 32'h12341234 || adr_s !== 32'h100) begin
      n_fail++;
      $display("FAIL store_h_bus: sel=%b dat=%h adr=%h, want 1100 12341234 00000100", sel_s, dat_s, adr_s);
    end
    run_txn(1'b0, SZ_HU, 32'h102, 32'h0, 32'h00001234, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    run_txn(1'b0, SZ_H,  32'h100, 32'h0, 32'hFFFF8000, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    n_tests++;
    if (sel_s !== 4'b0011) begin
      n_fail++;
      $display("FAIL load_h_sel: got %b want 0011", sel_s);
    end
    run_txn(1'b0, SZ_B,  32'h103, 32'h0, 32'h00000012, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
  endtask

  task automatic test_misalign;
    int lat, stb_n, wait_n, cyc_n; logic [3:0] sel_s; logic [31:0] dat_s, adr_s; logic we_s;
    logic [2:0] sizes [4];
    logic [31:0] addrs [4];
    sizes[0] = SZ_W;   addrs[0] = 32'h102;
    sizes[1] = SZ_H;   addrs[1] = 32'h101;
    sizes[2] = 3'b011; addrs[2] = 32'h100;
    sizes[3] = 3'b110; addrs[3] = 32'h100;
    for (int i = 0; i < 4; i++) begin
      run_txn(i[0], sizes[i], addrs[i], 32'h55AA55AA, 32'h0, 1'b1, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
      n_tests++;
      if (lat != 1 || cyc_n != 0) begin
        n_fail++;
        $display("FAIL misalign_%0d: resp at %0d cyc cycles %0d, want 1 and 0", i, lat, cyc_n);
      end
    end
  endtask

  task automatic test_bus_err;
    int lat, stb_n, wait_n, cyc_n; logic [3:0] sel_s; logic [31:0] dat_s, adr_s; logic we_s;
    give_err = 1'b1;
    run_txn(1'b0, SZ_W, 32'h100, 32'h0, 32'h0, 1'b1, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    give_err = 1'b0;
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL bus_err_timing: resp at %0d want 3", lat);
    end
  endtask

  task automatic test_timeout;
    int lat, stb_n, wait_n, cyc_n; logic [3:0] sel_s; logic [31:0] dat_s, adr_s; logic we_s;
    stall_cfg = 3;
    no_ack    = 1'b1;
    run_txn(1'b0, SZ_W, 32'h104, 32'h0, 32'h0, 1'b1, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    stall_cfg = 0;
    no_ack    = 1'b0;
    n_tests++;
    if (stb_n != 4 || wait_n != 15) begin
      n_fail++;
      $display("FAIL timeout_shape: stb %0d cycles, cyc-only %0d cycles, want 4 and 15", stb_n, wait_n);
    end
  endtask

  task automatic test_reset_mid;
    logic got_resp;
    logic cyc_seen;
    no_ack = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (wb_bus.wb_cyc_o !== 1'b1 || wb_bus.wb_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_ack: cyc=%b stb=%b, want 1 0", wb_bus.wb_cyc_o, wb_bus.wb_stb_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (wb_bus.wb_cyc_o !== 1'b0 || wb_bus.wb_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: cyc=%b stb=%b, want 0 0", wb_bus.wb_cyc_o, wb_bus.wb_stb_o);
    end
    rst = 1'b0;
    inject_ack = 1'b1;
    got_resp = 1'b0;
    cyc_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) got_resp = 1'b1;
      if (wb_bus.wb_cyc_o) cyc_seen = 1'b1;
    end
    inject_ack = 1'b0;
    no_ack     = 1'b0;
    n_tests++;
    if (got_resp !== 1'b0 || cyc_seen !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: resp=%b cyc=%b rdata=%h err=%b, want 0 0 0 0", got_resp, cyc_seen, resp_rdata, resp_err);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_abort: got %b want 1", req_ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat, stb_n, wait_n, cyc_n; logic [3:0] sel_s; logic [31:0] dat_s, adr_s; logic we_s;
    run_txn(1'b1, SZ_B, 32'h109, 32'h000000A5, 32'h0, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    n_tests++;
    if (sel_s !== 4'b0010 || dat_s !== 32'hA5A5A5A5 || adr_s !== 32'h108) begin
      n_fail++;
      $display("FAIL store_b_bus: sel=%b dat=%h adr=%h, want 0010 A5A5A5A5 00000108", sel_s, dat_s, adr_s);
    end
    run_txn(1'b0, SZ_BU, 32'h109, 32'h0, 32'h000000A5, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    run_txn(1'b0, SZ_B,  32'h109, 32'h0, 32'hFFFFFFA5, 1'b0, lat, stb_n, wait_n, cyc_n, sel_s, dat_s, adr_s, we_s);
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL b2b_latency: resp at %0d want 3", lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_bus_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
